// File: rtl/quadratic_root_search_pkg.sv
// Shared encodings for the quadratic root search: FSM states, operand-select and ALU mux codes.
// No logic; no latency; no backpressure.
package quadratic_root_search_pkg;

  // 13 of the 16 encodings are used; 13..15 fall back to S_LOAD_A.
  typedef enum logic [3:0] {
    S_LOAD_A      = 4'd0,
    S_LOAD_A_WAIT = 4'd1,
    S_LOAD_B      = 4'd2,
    S_LOAD_B_WAIT = 4'd3,
    S_LOAD_C      = 4'd4,
    S_LOAD_C_WAIT = 4'd5,
    S_LOAD_Y      = 4'd6,
    S_LOAD_Y_WAIT = 4'd7,
    S_EVAL_0      = 4'd8,
    S_EVAL_1      = 4'd9,
    S_CHECK       = 4'd10,
    S_DONE        = 4'd11,
    S_DONE_WAIT   = 4'd12
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_Y = 2'd3;

  localparam logic [1:0] MUL_SRC_A   = 2'd0;
  localparam logic [1:0] MUL_SRC_ACC = 2'd1;
  localparam logic [1:0] ADD_SRC_B   = 2'd0;
  localparam logic [1:0] ADD_SRC_C   = 2'd1;

endpackage

// File: rtl/qrs_control.sv
// Control FSM: sequences operand loads via go press/release, then steps the Horner search.
// Latency: 3 cycles per candidate x; backpressure: go handshake only, go ignored while busy.
module qrs_control
  import quadratic_root_search_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       match,
  input  logic       x_max,
  output logic [1:0] load_sel,
  output logic       ld_en,
  output logic       x_clr,
  output logic       x_inc,
  output logic       acc_ld,
  output logic [1:0] mul_sel,
  output logic [1:0] add_sel,
  output logic       res_found,
  output logic       res_none,
  output logic       busy,
  output logic       done
);

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_LOAD_A;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_LOAD_A;
    load_sel  = SEL_A;
    ld_en     = 1'b0;
    x_clr     = 1'b0;
    x_inc     = 1'b0;
    acc_ld    = 1'b0;
    mul_sel   = MUL_SRC_A;
    add_sel   = ADD_SRC_B;
    res_found = 1'b0;
    res_none  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_LOAD_A: begin
        ld_en = 1'b1;
        state_nxt = go ? S_LOAD_A_WAIT : S_LOAD_A;
      end
      S_LOAD_A_WAIT: state_nxt = go ? S_LOAD_A_WAIT : S_LOAD_B;
      S_LOAD_B: begin
        load_sel = SEL_B;
        ld_en = 1'b1;
        state_nxt = go ? S_LOAD_B_WAIT : S_LOAD_B;
      end
      S_LOAD_B_WAIT: begin
        load_sel = SEL_B;
        state_nxt = go ? S_LOAD_B_WAIT : S_LOAD_C;
      end
      S_LOAD_C: begin
        load_sel = SEL_C;
        ld_en = 1'b1;
        state_nxt = go ? S_LOAD_C_WAIT : S_LOAD_C;
      end
      S_LOAD_C_WAIT: begin
        load_sel = SEL_C;
        state_nxt = go ? S_LOAD_C_WAIT : S_LOAD_Y;
      end
      S_LOAD_Y: begin
        load_sel = SEL_Y;
        ld_en = 1'b1;
        state_nxt = go ? S_LOAD_Y_WAIT : S_LOAD_Y;
      end
      S_LOAD_Y_WAIT: begin
        load_sel = SEL_Y;
        x_clr = ~go;
        state_nxt = go ? S_LOAD_Y_WAIT : S_EVAL_0;
      end
      S_EVAL_0: begin
        busy = 1'b1;
        acc_ld = 1'b1;
        state_nxt = S_EVAL_1;
      end
      S_EVAL_1: begin
        busy = 1'b1;
        acc_ld = 1'b1;
        mul_sel = MUL_SRC_ACC;
        add_sel = ADD_SRC_C;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (match) begin
          res_found = 1'b1;
          state_nxt = S_DONE;
        end else if (x_max) begin
          res_none = 1'b1;
          state_nxt = S_DONE;
        end else begin
          x_inc = 1'b1;
          state_nxt = S_EVAL_0;
        end
      end
      S_DONE: begin
        done = 1'b1;
        state_nxt = go ? S_DONE_WAIT : S_DONE;
      end
      S_DONE_WAIT: begin
        done = 1'b1;
        state_nxt = go ? S_DONE_WAIT : S_LOAD_A;
      end
      default: state_nxt = S_LOAD_A;
    endcase
  end

endmodule

// File: rtl/qrs_datapath.sv
// Operand registers, x counter, accumulator, shared multiply-add ALU and result registers.
// Latency: one register stage per control step; no backpressure.
module qrs_datapath
  import quadratic_root_search_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       load_sel,
  input  logic             ld_en,
  input  logic             x_clr,
  input  logic             x_inc,
  input  logic             acc_ld,
  input  logic [1:0]       mul_sel,
  input  logic [1:0]       add_sel,
  input  logic             res_found,
  input  logic             res_none,
  output logic             match,
  output logic             x_max,
  output logic             found,
  output logic [WIDTH-1:0] x_result
);

  logic [WIDTH-1:0] a_reg, b_reg, c_reg, y_reg, x_reg, acc;
  logic [WIDTH-1:0] mul_a, add_b, prod, alu_out;

  always_comb begin
    mul_a = a_reg;
    add_b = b_reg;
    if (mul_sel == MUL_SRC_ACC) mul_a = acc;
    if (add_sel == ADD_SRC_C)   add_b = c_reg;
  end

  // Both operations wrap modulo 2^WIDTH by sizing to WIDTH bits.
  assign prod    = mul_a * x_reg;
  assign alu_out = prod + add_b;
  assign match   = (acc == y_reg);
  assign x_max   = (x_reg == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      y_reg    <= '0;
      x_reg    <= '0;
      acc      <= '0;
      x_result <= '0;
      found    <= 1'b0;
    end else begin
      if (ld_en) begin
        case (load_sel)
          SEL_A:   a_reg <= data_in;
          SEL_B:   b_reg <= data_in;
          SEL_C:   c_reg <= data_in;
          default: y_reg <= data_in;
        endcase
      end
      if (x_clr)      x_reg <= '0;
      else if (x_inc) x_reg <= x_reg + 1'b1;
      if (acc_ld) acc <= alu_out;
      if (res_found) begin
        x_result <= x_reg;
        found    <= 1'b1;
      end else if (res_none) begin
        x_result <= {WIDTH{1'b1}};
        found    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/quadratic_root_search.sv
// Finds the smallest x with A*x^2 + B*x + C == Y (mod 2^WIDTH) after a four-operand go-handshake load.
// Latency: 3*(k+1) cycles for a root at k, 3*2^WIDTH if none; no backpressure beyond go.
module quadratic_root_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [1:0]       load_sel,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] x_result
);

  logic       ld_en, x_clr, x_inc, acc_ld, res_found, res_none, match, x_max;
  logic [1:0] mul_sel, add_sel;

  qrs_control u_control (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .match     (match),
    .x_max     (x_max),
    .load_sel  (load_sel),
    .ld_en     (ld_en),
    .x_clr     (x_clr),
    .x_inc     (x_inc),
    .acc_ld    (acc_ld),
    .mul_sel   (mul_sel),
    .add_sel   (add_sel),
    .res_found (res_found),
    .res_none  (res_none),
    .busy      (busy),
    .done      (done)
  );

  qrs_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .resetn    (resetn),
    .data_in   (data_in),
    .load_sel  (load_sel),
    .ld_en     (ld_en),
    .x_clr     (x_clr),
    .x_inc     (x_inc),
    .acc_ld    (acc_ld),
    .mul_sel   (mul_sel),
    .add_sel   (add_sel),
    .res_found (res_found),
    .res_none  (res_none),
    .match     (match),
    .x_max     (x_max),
    .found     (found),
    .x_result  (x_result)
  );

endmodule
